// File: rtl/mux_onehot_reg.sv
// Registered one-hot multiplexer with a one-entry valid/ready output stage.
// Optional select checking (zeroed data, SEL_ERR flag, ERR_CNT) is enabled by MUX_ONEHOT_REG_CHECK_EN.
module mux_onehot_reg #(
    parameter int BITWIDTH = 32,
    parameter int NCH      = 4
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [NCH*BITWIDTH-1:0] DI,
    input  logic [NCH-1:0]          SEL,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [BITWIDTH-1:0]     DO,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    SEL_ERR,
    output logic [7:0]              ERR_CNT
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                accept_s;
    logic                consume_s;
    logic [BITWIDTH-1:0] data_or_s;
    logic [BITWIDTH-1:0] data_sel_s;
    logic [BITWIDTH-1:0] do_r;

    // The stage can take a word when empty or when the held word leaves this cycle.
    assign IN_READY  = (state_r == ST_EMPTY) | OUT_READY;
    assign accept_s  = IN_VALID & IN_READY;
    assign consume_s = (state_r == ST_FULL) & OUT_READY;
    assign OUT_VALID = (state_r == ST_FULL);
    assign DO        = do_r;

    // OR of every selected channel; equals the selected channel for a one-hot SEL.
    always_comb begin
        data_or_s = {BITWIDTH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (SEL[i]) begin
                data_or_s = data_or_s | DI[i*BITWIDTH +: BITWIDTH];
            end else begin
                data_or_s = data_or_s;
            end
        end
    end

`ifdef MUX_ONEHOT_REG_CHECK_EN
    localparam logic [NCH-1:0] ONE_L = {{(NCH-1){1'b0}}, 1'b1};

    logic       onehot_s;
    logic       sel_err_r;
    logic [7:0] err_cnt_r;

    function automatic logic is_onehot(input logic [NCH-1:0] v);
        return (v != {NCH{1'b0}}) && ((v & (v - ONE_L)) == {NCH{1'b0}});
    endfunction

    // Non-one-hot selects resolve to all-zero data.
    always_comb begin
        onehot_s = is_onehot(SEL);
        if (onehot_s) begin
            data_sel_s = data_or_s;
        end else begin
            data_sel_s = {BITWIDTH{1'b0}};
        end
    end

    // Error flag travels with the held word.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sel_err_r <= 1'b0;
        end else if (accept_s) begin
            sel_err_r <= ~onehot_s;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    // Saturating count of accepted bad selects, cleared only by reset.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            err_cnt_r <= 8'd0;
        end else if (accept_s && !onehot_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign SEL_ERR = sel_err_r;
    assign ERR_CNT = err_cnt_r;
`else
    // Without checking, non-one-hot selects simply OR the selected channels.
    always_comb begin
        data_sel_s = data_or_s;
    end

    assign SEL_ERR = 1'b0;
    assign ERR_CNT = 8'd0;
`endif

    // Next-state logic for the EMPTY/FULL output stage.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (consume_s && !accept_s) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Stage occupancy register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Data register loads only on accept, so a stalled word stays frozen.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            do_r <= {BITWIDTH{1'b0}};
        end else if (accept_s) begin
            do_r <= data_sel_s;
        end else begin
            do_r <= do_r;
        end
    end

endmodule

// File: tb/tb_mux_onehot_reg.sv
// Self-checking bench for mux_onehot_reg: directed steps plus randomized traffic
// compared against a behavioural model; honours MUX_ONEHOT_REG_CHECK_EN.
module tb_mux_onehot_reg;

    localparam int BW = 32;
    localparam int N  = 4;
`ifdef MUX_ONEHOT_REG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N*BW-1:0] di;
    logic [N-1:0]    sel;
    logic            in_valid;
    logic            out_ready;
    logic            in_ready;
    logic [BW-1:0]   dout;
    logic            out_valid;
    logic            sel_err;
    logic [7:0]      err_cnt;

    logic [63:0]     di8;
    logic [7:0]      sel8;
    logic            in_valid8;
    logic            out_ready8;
    logic            in_ready8;
    logic [7:0]      dout8;
    logic            out_valid8;
    logic            sel_err8;
    logic [7:0]      err_cnt8;

    // model state
    logic            m_valid;
    logic [BW-1:0]   m_do;
    logic            m_err;
    int              m_cnt;

    int checks = 0;
    int errors = 0;

    mux_onehot_reg #(.BITWIDTH(BW), .NCH(N)) u_dut (
        .CLK(clk), .RSTn(rstn), .DI(di), .SEL(sel), .IN_VALID(in_valid),
        .IN_READY(in_ready), .DO(dout), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .SEL_ERR(sel_err), .ERR_CNT(err_cnt)
    );

    mux_onehot_reg #(.BITWIDTH(8), .NCH(8)) u_dut8 (
        .CLK(clk), .RSTn(rstn), .DI(di8), .SEL(sel8), .IN_VALID(in_valid8),
        .IN_READY(in_ready8), .DO(dout8), .OUT_VALID(out_valid8),
        .OUT_READY(out_ready8), .SEL_ERR(sel_err8), .ERR_CNT(err_cnt8)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] ref_word(input logic [N*BW-1:0] d, input logic [N-1:0] s);
        logic [BW-1:0] acc;
        acc = '0;
        if ($countones(s) == 1) begin
            for (int i = 0; i < N; i++) if (s[i]) acc = d[i*BW +: BW];
        end else if (!CHK) begin
            for (int i = 0; i < N; i++) if (s[i]) acc = acc | d[i*BW +: BW];
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_do    = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic acc;
        acc = in_valid && (!m_valid || out_ready);
        if (acc) begin
            m_do    = ref_word(di, sel);
            m_err   = CHK && ($countones(sel) != 1);
            if (m_err && m_cnt < 255) m_cnt++;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_cnt));
        if (m_valid) begin
            chk({tag, ".do"}, 64'(dout), 64'(m_do));
            chk({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
        end
    endtask

    initial begin
        logic [31:0] stream_exp [4];
        stream_exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        di = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0;
        di8 = '0; sel8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
        model_reset();

        // reset values
        #12;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.do", 64'(dout), 64'd0);
        chk("rst.sel_err", 64'(sel_err), 64'd0);
        chk("rst.err_cnt", 64'(err_cnt), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst");

        // first transfer
        di = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel = 4'b0100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check_all("tp1");
        chk("tp1.do_const", 64'(dout), 64'h33333333);

        // back-to-back stream
        for (int k = 0; k < 4; k++) begin
            sel = 4'(1 << k);
            tick();
            check_all("stream");
            chk("stream.do_const", 64'(dout), 64'(stream_exp[k]));
            chk("stream.in_ready", 64'(in_ready), 64'd1);
        end

        // stall holds the word
        sel = 4'b0010;
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            di = {$urandom, $urandom, $urandom, $urandom};
            sel = 4'($urandom);
            tick();
            check_all("stall");
            chk("stall.do_const", 64'(dout), 64'h22222222);
            chk("stall.in_ready", 64'(in_ready), 64'd0);
        end
        di = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        sel = 4'b1000; out_ready = 1'b1;
        tick();
        check_all("release");
        chk("release.do_const", 64'(dout), 64'h44444444);
        chk("release.out_valid", 64'(out_valid), 64'd1);

        // non-one-hot selects
        sel = 4'b0000;
        tick();
        check_all("sel0");
        chk("sel0.do_const", 64'(dout), 64'd0);
        sel = 4'b0011;
        tick();
        check_all("sel3");
        chk("sel3.do_const", 64'(dout), CHK ? 64'd0 : 64'h33333333);
        chk("sel3.sel_err", 64'(sel_err), CHK ? 64'd1 : 64'd0);
        chk("sel3.err_cnt", 64'(err_cnt), CHK ? 64'd2 : 64'd0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            di = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 0) sel = 4'(1 << $urandom_range(0, N-1));
            else sel = 4'($urandom);
            tick();
            check_all("rand");
        end

        // counter saturation
        in_valid = 1'b1; out_ready = 1'b1; sel = 4'b0000;
        repeat (300) tick();
        check_all("sat");
        chk("sat.err_cnt", 64'(err_cnt), CHK ? 64'd255 : 64'd0);

        // asynchronous reset while full
        out_ready = 1'b0; sel = 4'b0100;
        tick();
        chk("mid.out_valid_pre", 64'(out_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("mid.out_valid", 64'(out_valid), 64'd0);
        chk("mid.do", 64'(dout), 64'd0);
        chk("mid.sel_err", 64'(sel_err), 64'd0);
        chk("mid.err_cnt", 64'(err_cnt), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check_all("after_mid");

        // 8-channel, 8-bit instance
        di8 = {$urandom, $urandom};
        di8[63:56] = 8'hA5;
        sel8 = 8'h80; in_valid8 = 1'b1;
        tick();
        chk("n8.do", 64'(dout8), 64'hA5);
        chk("n8.out_valid", 64'(out_valid8), 64'd1);
        chk("n8.sel_err", 64'(sel_err8), 64'd0);
        di8 = {$urandom, $urandom};
        sel8 = 8'h01;
        tick();
        chk("n8.do_ch0", 64'(dout8), 64'(di8[7:0]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
